// File: rtl/qspi_weight_streamer.sv
// Streams TOTAL_WORDS weight words from SPI flash (0x03 single read) out over a valid/ready port.
// Define QSPI_WEIGHT_STREAMER_QSPI_EN to use the 0x6B quad-output read with 8 dummy periods instead.
module qspi_weight_streamer #(
    parameter int DATA_WIDTH  = 8,
    parameter int TOTAL_WORDS = 64,
    parameter int ADDR_WIDTH  = 24
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [ADDR_WIDTH-1:0]            base_addr,
    output logic                             flash_csb,
    output logic                             flash_clk,
    output logic                             flash_io0_oe,
    output logic                             flash_io1_oe,
    output logic                             flash_io2_oe,
    output logic                             flash_io3_oe,
    output logic                             flash_io0_do,
    output logic                             flash_io1_do,
    output logic                             flash_io2_do,
    output logic                             flash_io3_do,
    input  logic                             flash_io0_di,
    input  logic                             flash_io1_di,
    input  logic                             flash_io2_di,
    input  logic                             flash_io3_di,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic [$clog2(TOTAL_WORDS)-1:0]   out_index,
    output logic                             weights_ready
);

    localparam int IDX_W = $clog2(TOTAL_WORDS);
    localparam int TX_W  = 8 + ADDR_WIDTH;
`ifdef QSPI_WEIGHT_STREAMER_QSPI_EN
    localparam logic [7:0] CMD_BYTE = 8'h6B;
    localparam int         BPP      = 4;
`else
    localparam logic [7:0] CMD_BYTE = 8'h03;
    localparam int         BPP      = 1;
`endif
    localparam int PPW   = DATA_WIDTH / BPP;
    localparam int CNT_W = $clog2(TX_W + DATA_WIDTH) + 1;

    localparam logic [CNT_W-1:0] CNT_CMD_LAST   = CNT_W'(7);
    localparam logic [CNT_W-1:0] CNT_TX_LAST    = CNT_W'(TX_W - 1);
    localparam logic [CNT_W-1:0] CNT_WORD_LAST  = CNT_W'(PPW - 1);
`ifdef QSPI_WEIGHT_STREAMER_QSPI_EN
    localparam logic [CNT_W-1:0] CNT_DUMMY_LAST = CNT_W'(7);
`endif
    localparam logic [IDX_W-1:0] IDX_LAST       = IDX_W'(TOTAL_WORDS - 1);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, HOLD, DONE} state_t;

    state_t                    state_q;
    logic                      csb_q;
    logic                      sclk_q;
    logic                      io0_oe_q;
    logic                      io0_do_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [TX_W-1:0]           tx_q;
    logic [DATA_WIDTH-BPP-1:0] shift_q;
    logic [DATA_WIDTH-1:0]     out_data_q;
    logic [IDX_W-1:0]          out_index_q;
    logic                      out_valid_q;
    logic                      weights_ready_q;
    logic [BPP-1:0]            rx_bits;
    logic [DATA_WIDTH-1:0]     rx_word;

`ifdef QSPI_WEIGHT_STREAMER_QSPI_EN
    assign rx_bits = {flash_io3_di, flash_io2_di, flash_io1_di, flash_io0_di};
`else
    logic unused_di;
    assign rx_bits   = flash_io1_di;
    assign unused_di = flash_io0_di ^ flash_io2_di ^ flash_io3_di;
`endif

    // Earlier bits sit in the upper positions, so the first byte lands in the MSB byte.
    assign rx_word = {shift_q, rx_bits};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            csb_q           <= 1'b1;
            sclk_q          <= 1'b0;
            io0_oe_q        <= 1'b0;
            io0_do_q        <= 1'b0;
            cnt_q           <= '0;
            tx_q            <= '0;
            shift_q         <= '0;
            out_data_q      <= '0;
            out_index_q     <= '0;
            out_valid_q     <= 1'b0;
            weights_ready_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q         <= CMD;
                        csb_q           <= 1'b0;
                        io0_oe_q        <= 1'b1;
                        io0_do_q        <= CMD_BYTE[7];
                        tx_q            <= {CMD_BYTE[6:0], base_addr, 1'b0};
                        cnt_q           <= '0;
                        out_index_q     <= '0;
                        weights_ready_q <= 1'b0;
                    end
                end
                CMD, ADDR: begin
                    sclk_q <= ~sclk_q;
                    if (sclk_q) begin
                        if (cnt_q == CNT_TX_LAST) begin
                            io0_oe_q <= 1'b0;
                            io0_do_q <= 1'b0;
                            cnt_q    <= '0;
`ifdef QSPI_WEIGHT_STREAMER_QSPI_EN
                            state_q  <= DUMMY;
`else
                            state_q  <= DATA;
`endif
                        end else begin
                            io0_do_q <= tx_q[TX_W-1];
                            tx_q     <= {tx_q[TX_W-2:0], 1'b0};
                            cnt_q    <= cnt_q + 1'b1;
                            if (cnt_q == CNT_CMD_LAST) begin
                                state_q <= ADDR;
                            end
                        end
                    end
                end
`ifdef QSPI_WEIGHT_STREAMER_QSPI_EN
                DUMMY: begin
                    sclk_q <= ~sclk_q;
                    if (sclk_q) begin
                        if (cnt_q == CNT_DUMMY_LAST) begin
                            cnt_q   <= '0;
                            state_q <= DATA;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
`endif
                DATA: begin
                    sclk_q <= ~sclk_q;
                    if (sclk_q) begin
                        if (cnt_q == CNT_WORD_LAST) begin
                            out_data_q  <= rx_word;
                            out_valid_q <= 1'b1;
                            cnt_q       <= '0;
                            state_q     <= HOLD;
                        end else begin
                            shift_q <= rx_word[DATA_WIDTH-BPP-1:0];
                            cnt_q   <= cnt_q + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    // flash_clk is parked low here, so the flash cannot advance past the held word.
                    if (out_valid_q && out_ready) begin
                        out_valid_q <= 1'b0;
                        if (out_index_q == IDX_LAST) begin
                            state_q         <= DONE;
                            csb_q           <= 1'b1;
                            weights_ready_q <= 1'b1;
                        end else begin
                            out_index_q <= out_index_q + 1'b1;
                            state_q     <= DATA;
                        end
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    csb_q    <= 1'b1;
                    sclk_q   <= 1'b0;
                    io0_oe_q <= 1'b0;
                    io0_do_q <= 1'b0;
                end
            endcase
        end
    end

    assign flash_csb     = csb_q;
    assign flash_clk     = sclk_q;
    assign flash_io0_oe  = io0_oe_q;
    assign flash_io0_do  = io0_do_q;
    assign flash_io1_oe  = 1'b0;
    assign flash_io2_oe  = 1'b0;
    assign flash_io3_oe  = 1'b0;
    assign flash_io1_do  = 1'b0;
    assign flash_io2_do  = 1'b0;
    assign flash_io3_do  = 1'b0;
    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;
    assign out_index     = out_index_q;
    assign weights_ready = weights_ready_q;

endmodule

// File: tb/tb_qspi_weight_streamer.sv
// Scoreboard bench for qspi_weight_streamer: an 8-bit/64-word instance and a 16-bit/2-word instance,
// each driven by a behavioural flash model; expectations follow QSPI_WEIGHT_STREAMER_QSPI_EN.
module tb_qspi_weight_streamer;

    localparam int AW = 24;
    localparam int NW = 64;
`ifdef QSPI_WEIGHT_STREAMER_QSPI_EN
    localparam bit         QUAD    = 1'b1;
    localparam logic [7:0] EXP_CMD = 8'h6B;
    localparam int         NDUMMY  = 8;
`else
    localparam bit         QUAD    = 1'b0;
    localparam logic [7:0] EXP_CMD = 8'h03;
    localparam int         NDUMMY  = 0;
`endif
    localparam int DSTART = 8 + AW + NDUMMY;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] a_byte(input int k);
        if (QUAD && k == 0) return 8'hA5;
        return 8'(k + 1);
    endfunction

    function automatic logic [7:0] b_byte(input int k);
        logic [7:0] t [4];
        t = '{8'h12, 8'h34, 8'h56, 8'h78};
        return t[k % 4];
    endfunction

    function automatic int byte_of(input int j);
        return QUAD ? j / 2 : j / 8;
    endfunction

    function automatic logic [3:0] pins(input logic [7:0] b, input int j);
        logic [3:0] r;
        r = 4'b0000;
        if (QUAD) r = (j % 2 == 0) ? b[7:4] : b[3:0];
        else      r[1] = b[7 - (j % 8)];
        return r;
    endfunction

    // Instance A: 8-bit words, 64 per load
    logic          a_start = 1'b0;
    logic [AW-1:0] a_base  = '0;
    logic          a_csb, a_sclk, a_valid, a_wr;
    logic          a_ready = 1'b1;
    logic [3:0]    a_oe, a_do;
    logic [3:0]    a_di = 4'b0000;
    logic [7:0]    a_data;
    logic [5:0]    a_idx;

    qspi_weight_streamer #(.DATA_WIDTH(8), .TOTAL_WORDS(NW), .ADDR_WIDTH(AW)) u_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .base_addr(a_base),
        .flash_csb(a_csb), .flash_clk(a_sclk),
        .flash_io0_oe(a_oe[0]), .flash_io1_oe(a_oe[1]), .flash_io2_oe(a_oe[2]), .flash_io3_oe(a_oe[3]),
        .flash_io0_do(a_do[0]), .flash_io1_do(a_do[1]), .flash_io2_do(a_do[2]), .flash_io3_do(a_do[3]),
        .flash_io0_di(a_di[0]), .flash_io1_di(a_di[1]), .flash_io2_di(a_di[2]), .flash_io3_di(a_di[3]),
        .out_valid(a_valid), .out_ready(a_ready), .out_data(a_data), .out_index(a_idx),
        .weights_ready(a_wr));

    // Instance B: 16-bit words, 2 per load
    logic          b_start = 1'b0;
    logic [AW-1:0] b_base  = '0;
    logic          b_csb, b_sclk, b_valid, b_wr;
    logic          b_ready = 1'b1;
    logic [3:0]    b_oe, b_do;
    logic [3:0]    b_di = 4'b0000;
    logic [15:0]   b_data;
    logic [0:0]    b_idx;

    qspi_weight_streamer #(.DATA_WIDTH(16), .TOTAL_WORDS(2), .ADDR_WIDTH(AW)) u_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .base_addr(b_base),
        .flash_csb(b_csb), .flash_clk(b_sclk),
        .flash_io0_oe(b_oe[0]), .flash_io1_oe(b_oe[1]), .flash_io2_oe(b_oe[2]), .flash_io3_oe(b_oe[3]),
        .flash_io0_do(b_do[0]), .flash_io1_do(b_do[1]), .flash_io2_do(b_do[2]), .flash_io3_do(b_do[3]),
        .flash_io0_di(b_di[0]), .flash_io1_di(b_di[1]), .flash_io2_di(b_di[2]), .flash_io3_di(b_di[3]),
        .out_valid(b_valid), .out_ready(b_ready), .out_data(b_data), .out_index(b_idx),
        .weights_ready(b_wr));

    // Flash models: capture command/address on io0 at each rising flash_clk, then present read data
    int            a_cnt = 0, b_cnt = 0;
    int            a_bad = 0, b_bad = 0;
    logic [7:0]    a_cmd = '0, b_cmd = '0;
    logic [AW-1:0] a_addr = '0, b_addr = '0;

    always @(posedge a_csb) a_cnt = 0;
    always @(posedge b_csb) b_cnt = 0;

    always @(posedge a_sclk) begin
        if (a_csb == 1'b0) begin
            if (a_do[3:1] !== 3'b000) a_bad++;
            if (a_cnt < 8) begin
                a_cmd = {a_cmd[6:0], a_do[0]};
                if (a_oe !== 4'b0001) a_bad++;
            end else if (a_cnt < 8 + AW) begin
                a_addr = {a_addr[AW-2:0], a_do[0]};
                if (a_oe !== 4'b0001) a_bad++;
            end else begin
                if (a_oe !== 4'b0000) a_bad++;
                if (a_cnt >= DSTART) a_di = pins(a_byte(byte_of(a_cnt - DSTART)), a_cnt - DSTART);
            end
            a_cnt++;
        end
    end

    always @(posedge b_sclk) begin
        if (b_csb == 1'b0) begin
            if (b_do[3:1] !== 3'b000) b_bad++;
            if (b_cnt < 8) begin
                b_cmd = {b_cmd[6:0], b_do[0]};
                if (b_oe !== 4'b0001) b_bad++;
            end else if (b_cnt < 8 + AW) begin
                b_addr = {b_addr[AW-2:0], b_do[0]};
                if (b_oe !== 4'b0001) b_bad++;
            end else begin
                if (b_oe !== 4'b0000) b_bad++;
                if (b_cnt >= DSTART) b_di = pins(b_byte(byte_of(b_cnt - DSTART)), b_cnt - DSTART);
            end
            b_cnt++;
        end
    end

    // Scoreboards: expected {index, data} pushed at start, popped on every handshake
    logic [31:0] a_q [$];
    logic [31:0] b_q [$];

    always @(negedge clk) begin
        if (rst_n && a_valid && a_ready) begin
            if (a_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL a_extra_word actual=%0h required=none", {a_idx, a_data});
            end else begin
                check("a_word", {18'd0, a_idx, a_data}, a_q.pop_front());
            end
        end
        if (rst_n && b_valid && b_ready) begin
            if (b_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL b_extra_word actual=%0h required=none", {b_idx, b_data});
            end else begin
                check("b_word", {15'd0, b_idx, b_data}, b_q.pop_front());
            end
        end
    end

    // Back-pressure: hold word 5 for 20 cycles, checking the port and flash clock stay frozen
    bit stalled = 1'b0;
    initial begin
        forever begin
            @(posedge clk); #1;
            if (!stalled && a_valid && a_idx == 6'd5) begin
                stalled = 1'b1;
                a_ready = 1'b0;
                repeat (20) begin
                    @(posedge clk); #1;
                    check("stall_hold", {a_sclk, a_csb, a_valid, a_idx, a_data},
                          {1'b0, 1'b0, 1'b1, 6'd5, a_byte(5)});
                end
                a_ready = 1'b1;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #2 rst_n = 1'b0;
        #1;
        check("a_reset", {a_csb, a_sclk, a_oe, a_do, a_valid, a_data, a_idx, a_wr}, 32'h0200_0000);
        check("b_reset", {b_csb, b_sclk, b_oe, b_do, b_valid, b_data, b_idx, b_wr}, 32'h1000_0000);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // 16-bit words: bytes 0x12,0x34 then 0x56,0x78
        b_q.push_back({15'd0, 1'b0, 16'h1234});
        b_q.push_back({15'd0, 1'b1, 16'h5678});
        @(posedge clk); #1 b_start = 1'b1; b_base = 24'h000200;
        @(posedge clk); #1 b_start = 1'b0;
        check("b_csb_after_start", {31'd0, b_csb}, 32'd0);
        for (int i = 0; i < 3000 && !b_wr; i++) begin @(posedge clk); #1; end
        check("b_weights_ready", {31'd0, b_wr}, 32'd1);
        check("b_cmd", {24'd0, b_cmd}, {24'd0, EXP_CMD});
        check("b_addr", {8'd0, b_addr}, 32'h0000_0200);
        check("b_pins", b_bad, 0);
        check("b_queue_left", b_q.size(), 0);

        // Abort a load during the address phase
        @(posedge clk); #1 a_start = 1'b1; a_base = 24'h000100;
        @(posedge clk); #1 a_start = 1'b0;
        check("a_csb_after_start", {31'd0, a_csb}, 32'd0);
        for (int i = 0; i < 200 && a_cnt < 12; i++) begin @(posedge clk); #1; end
        check("a_reach_addr", {31'd0, a_cnt >= 12}, 32'd1);
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        check("a_abort_reset", {a_csb, a_sclk, a_oe, a_valid, a_idx, a_wr}, {18'd0, 1'b1, 13'd0});
        #5 rst_n = 1'b1;

        // Full load after abort: words 0x01.. at index 0..63
        for (int k = 0; k < NW; k++) a_q.push_back({18'd0, 6'(k), a_byte(k)});
        @(posedge clk); #1 a_start = 1'b1; a_base = 24'h000100;
        @(posedge clk); #1 a_start = 1'b0;
        check("a_csb_restart", {31'd0, a_csb}, 32'd0);

        // start while streaming must be ignored
        for (int i = 0; i < 5000 && a_idx != 6'd10; i++) begin @(posedge clk); #1; end
        check("a_reach_idx10", {26'd0, a_idx}, 32'd10);
        @(posedge clk); #1 a_start = 1'b1;
        @(posedge clk); #1 a_start = 1'b0;
        check("a_start_ignored", {a_csb, a_idx}, {25'd0, 1'b0, 6'd10});

        for (int i = 0; i < 20000 && !a_wr; i++) begin @(posedge clk); #1; end
        check("a_weights_ready", {31'd0, a_wr}, 32'd1);
        check("a_done_pins", {a_csb, a_sclk, a_oe}, {26'd0, 1'b1, 1'b0, 4'b0000});
        check("a_cmd", {24'd0, a_cmd}, {24'd0, EXP_CMD});
        check("a_addr", {8'd0, a_addr}, 32'h0000_0100);
        check("a_pins", a_bad, 0);
        check("a_stall_seen", {31'd0, stalled}, 32'd1);
        check("a_queue_left", a_q.size(), 0);

        // start in DONE restarts and clears weights_ready
        @(posedge clk); #1 a_start = 1'b1;
        @(posedge clk); #1 a_start = 1'b0;
        check("a_done_restart", {a_wr, a_csb, a_idx}, 32'd0);
        #2 rst_n = 1'b0;
        #10;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/qspi_weight_streamer.md
QSPI_WEIGHT_STREAMER -- requirements
Module: qspi_weight_streamer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: weight word width in bits; multiple of 8, 8..32.
REQ-002 SHALL have parameter TOTAL_WORDS, default 64: weight words fetched per load.
REQ-003 SHALL have parameter ADDR_WIDTH, default 24: flash byte-address width.
REQ-004 SHALL have port clk  input  1: single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1: asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1: one-cycle load request; ignored unless IDLE or DONE.
REQ-007 SHALL have port base_addr  input  ADDR_WIDTH: flash byte address of the first weight; sampled on accepted start.
REQ-008 SHALL have port flash_csb  output  1: flash chip select, active low.
REQ-009 SHALL have port flash_clk  output  1: SPI clock, clk/2.
REQ-010 SHALL have ports flash_io0_oe..flash_io3_oe  output  1 each: pad output enables.
REQ-011 SHALL have ports flash_io0_do..flash_io3_do  output  1 each: pad output data.
REQ-012 SHALL have ports flash_io0_di..flash_io3_di  input  1 each: pad input data.
REQ-013 SHALL have port out_valid  output  1: out_data/out_index hold a complete word.
REQ-014 SHALL have port out_ready  input  1: consumer accepts the word when out_valid&&out_ready.
REQ-015 SHALL have port out_data  output  DATA_WIDTH: assembled signed weight word.
REQ-016 SHALL have port out_index  output  $clog2(TOTAL_WORDS): index of out_data, 0-based.
REQ-017 SHALL have port weights_ready  output  1: all TOTAL_WORDS accepted; held until next start.

Function
REQ-018 SHALL implement FSM states IDLE, CMD, ADDR, DUMMY, DATA, HOLD, DONE; accepted start -> CMD, csb low from the next cycle.
REQ-019 SHALL make each SPI bit-period two clk cycles: flash_clk low then high; outputs change on entry to the low phase; inputs sampled at the clk edge that ends the high phase.
REQ-020 SHALL send the 8-bit command MSB-first on io0 (io0_oe=1, io1..3_oe=0), then ADDR_WIDTH address bits MSB-first on io0.
REQ-021 SHALL use command 0x03 (single mode): DATA follows ADDR directly, one bit per period on io1.
REQ-022 SHALL pack bytes big-endian: the first received byte is out_data[DATA_WIDTH-1 -: 8].
REQ-023 SHALL enter HOLD and raise out_valid when a word completes; flash_clk stays low and csb stays low in HOLD; no bits are lost.
REQ-024 SHALL leave HOLD on out_valid&&out_ready: increment out_index, drop out_valid the next cycle unless another word completes; resume DATA; final-word acceptance -> DONE.
REQ-025 SHALL keep out_data and out_index stable while out_valid=1 and out_ready=0.
REQ-026 SHALL, in DONE, drive csb high, flash_clk low, weights_ready high; start in DONE restarts a load and clears weights_ready the next cycle.
REQ-027 SHALL ignore start in CMD..HOLD (no restart, no index change).
REQ-028 SHALL keep all io oe=0 in IDLE, DATA, HOLD and DONE.

Reset
REQ-029 SHALL, on rst_n low, immediately set state IDLE, flash_csb=1, flash_clk=0, all oe/do=0, out_valid=0, out_data=0, out_index=0, weights_ready=0.
REQ-030 SHALL, on reset mid-transfer, abandon the transfer; after release, the next start begins at CMD with index 0.

Configuration
REQ-031 SHALL, with macro QSPI_WEIGHT_STREAMER_QSPI_EN defined, use quad output read: command 0x6B, address on io0, 8 DUMMY bit-periods (all oe=0), then 4 bits per period, io3 the MSB nibble bit, io0 the LSB.
REQ-032 SHALL, without QSPI_WEIGHT_STREAMER_QSPI_EN, omit DUMMY and quad logic; behaviour per REQ-021; io2/io3 do=0, oe=0 always.

Verification
REQ-033 SHALL cover: single mode, base_addr=0x000100, flash model returns 0x01,0x02,... -> command 0x03, address 0x000100 on io0, words 0x01..0x40 index 0..63, then weights_ready=1.
REQ-034 SHALL cover: DATA_WIDTH=16, bytes 0x12,0x34 -> out_data=0x1234 at index 0.
REQ-035 SHALL cover: out_ready held 0 for 20 cycles on word 5 -> flash_clk low and out_data/out_index constant throughout; no missing or duplicate words.
REQ-036 SHALL cover: rst_n low during ADDR -> csb=1 at once; start after release -> fresh CMD, index 0.
REQ-037 SHALL cover: QSPI_EN defined, nibbles 0xA,0x5 -> command 0x6B, 8 dummy periods, out_data=0xA5; start during DATA ignored.
